// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter: FSM states, access
// types, default arbitration/watchdog limits and the timeout return pattern.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DATA_BUSY = 2'd1,
        INST_BUSY = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        ACC_LOAD  = 2'd0,
        ACC_STORE = 2'd1,
        ACC_FETCH = 2'd2
    } acc_type_e;

    localparam int          DEF_STARVE_LIMIT   = 4;
    localparam int          DEF_TIMEOUT_CYCLES = 16;
    localparam logic [31:0] TIMEOUT_DATA       = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle watchdog for the memory port arbiter. Counts cycles while 'run'
// is high and raises 'expired' during the LIMIT-th running cycle; 'clear'
// restarts the count at every grant.
module mem_arb_watchdog #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int            CW   = (LIMIT < 2) ? 1 : $clog2(LIMIT);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired = run & ~clear & (cnt_q == LAST);

    // Next count: restart on grant, advance while busy, wrap once expired.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = expired ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch, data load/store) in front of a
// single memory port. Data normally wins; fetch wins after STARVE_LIMIT
// consecutive losses. Optional busy watchdog: define MEM_PORT_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT   = DEF_STARVE_LIMIT,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_address,
    output logic        if_valid,
    output logic [31:0] if_data,
    input  logic        dm_load,
    input  logic        dm_store,
    input  logic [31:0] dm_address,
    input  logic [31:0] dm_wdata,
    output logic        dm_valid,
    output logic [31:0] dm_rdata,
    output logic [31:0] m_address,
    output logic [31:0] m_data_write,
    output logic        m_write_enable,
    output logic        m_read_enable,
    input  logic        m_data_valid,
    input  logic [31:0] m_data_read,
    output logic        stall,
    output logic        bus_error
);

    localparam int            SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_e    state_q;
    acc_type_e     acc_q;
    logic [SW-1:0] starve_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          if_valid_q;
    logic [31:0]   if_data_q;
    logic          dm_valid_q;
    logic [31:0]   dm_rdata_q;

    logic          busy;
    logic          dm_req;
    logic          fetch_win;
    logic          data_win;
    logic          wd_expired;
    logic          done;
    logic [31:0]   ret_data;

    assign busy      = (state_q != IDLE);
    assign dm_req    = dm_load | dm_store;
    // Fetch takes the port when data is idle or fetch has been starved long enough.
    assign fetch_win = ~busy & if_req & (~dm_req | (starve_q == STARVE_MAX));
    assign data_win  = ~busy & dm_req & ~fetch_win;

    // An access finishes on memory completion or, with the watchdog, on timeout.
    assign done      = m_data_valid | wd_expired;
    assign ret_data  = m_data_valid ? m_data_read : TIMEOUT_DATA;

    // Memory strobes decode from the latched access; reset clears state so
    // they drop without waiting for a clock.
    assign m_address      = addr_q;
    assign m_data_write   = wdata_q;
    assign m_write_enable = busy & (acc_q == ACC_STORE);
    assign m_read_enable  = busy & (acc_q != ACC_STORE);

    assign if_valid = if_valid_q;
    assign if_data  = if_data_q;
    assign dm_valid = dm_valid_q;
    assign dm_rdata = dm_rdata_q;

    // Freeze while an access is outstanding or while the losing requester waits.
    assign stall = ~reset & (busy | (if_req & dm_req));

    // Arbitration FSM: latch the winner in IDLE, hold it until completion,
    // then return the read data with a one-cycle valid pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= ACC_LOAD;
            starve_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_valid_q <= 1'b0;
            if_data_q  <= '0;
            dm_valid_q <= 1'b0;
            dm_rdata_q <= '0;
        end else begin
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (fetch_win) begin
                        state_q  <= INST_BUSY;
                        acc_q    <= ACC_FETCH;
                        addr_q   <= if_address;
                        starve_q <= '0;
                    end else if (data_win) begin
                        state_q <= DATA_BUSY;
                        acc_q   <= dm_store ? ACC_STORE : ACC_LOAD;
                        addr_q  <= dm_address;
                        wdata_q <= dm_wdata;
                        if (if_req && (starve_q != STARVE_MAX)) begin
                            starve_q <= starve_q + 1'b1;
                        end
                    end
                end
                DATA_BUSY: begin
                    if (done) begin
                        state_q    <= IDLE;
                        dm_valid_q <= 1'b1;
                        dm_rdata_q <= ret_data;
                    end
                end
                INST_BUSY: begin
                    if (done) begin
                        state_q    <= IDLE;
                        if_valid_q <= 1'b1;
                        if_data_q  <= ret_data;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    logic bus_error_q;

    mem_arb_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (fetch_win | data_win),
        .run    (busy),
        .expired(wd_expired)
    );

    // Flag a bus error on the same edge the FSM abandons a timed-out access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_error_q <= 1'b0;
        end else begin
            bus_error_q <= busy & ~m_data_valid & wd_expired;
        end
    end

    assign bus_error = bus_error_q;
`else
    assign wd_expired = 1'b0;
    assign bus_error  = 1'b0;

    // Keeps the timeout parameter referenced when the watchdog is compiled out.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. The bench plays the memory; every
// expected completion is queued when the response is driven and popped by a
// monitor when the arbiter raises if_valid or dm_valid.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_address = '0;
    logic        if_valid;
    logic [31:0] if_data;
    logic        dm_load = 1'b0;
    logic        dm_store = 1'b0;
    logic [31:0] dm_address = '0;
    logic [31:0] dm_wdata = '0;
    logic        dm_valid;
    logic [31:0] dm_rdata;
    logic [31:0] m_address;
    logic [31:0] m_data_write;
    logic        m_write_enable;
    logic        m_read_enable;
    logic        m_data_valid = 1'b0;
    logic [31:0] m_data_read = '0;
    logic        stall;
    logic        bus_error;

    mem_port_arbiter #(
        .STARVE_LIMIT  (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .if_req        (if_req),
        .if_address    (if_address),
        .if_valid      (if_valid),
        .if_data       (if_data),
        .dm_load       (dm_load),
        .dm_store      (dm_store),
        .dm_address    (dm_address),
        .dm_wdata      (dm_wdata),
        .dm_valid      (dm_valid),
        .dm_rdata      (dm_rdata),
        .m_address     (m_address),
        .m_data_write  (m_data_write),
        .m_write_enable(m_write_enable),
        .m_read_enable (m_read_enable),
        .m_data_valid  (m_data_valid),
        .m_data_read   (m_data_read),
        .stall         (stall),
        .bus_error     (bus_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          fetch;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   mcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; callers drive, then wait #2 to sample.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every valid pulse must match the oldest queued completion.
    always @(negedge clk) begin
        if (dm_valid === 1'b1 || if_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", {30'd0, if_valid, dm_valid}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk1("sb_if_valid", if_valid, mon_e.fetch);
                chk1("sb_dm_valid", dm_valid, ~mon_e.fetch);
                chk("sb_data", mon_e.fetch ? if_data : dm_rdata, mon_e.data);
            end
        end
    end

    initial begin
        // Reset state, observed without any clock edge.
        #1 reset = 1'b1;
        #1;
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_ren", m_read_enable, 1'b0);
        chk1("rst_wen", m_write_enable, 1'b0);
        chk1("rst_dm_valid", dm_valid, 1'b0);
        chk1("rst_if_valid", if_valid, 1'b0);
        chk1("rst_bus_error", bus_error, 1'b0);
        chk("rst_m_address", m_address, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        chk("rst_if_data", if_data, 32'h0);
        nxt();
        nxt();
        reset = 1'b0;

        // Minimum-latency load.
        nxt();
        dm_load = 1'b1;
        dm_address = 32'h100;
        #2;
        chk1("s1_stall_N", stall, 1'b0);
        chk1("s1_ren_N", m_read_enable, 1'b0);
        nxt(); #2;
        chk1("s1_ren_N1", m_read_enable, 1'b1);
        chk1("s1_wen_N1", m_write_enable, 1'b0);
        chk("s1_addr_N1", m_address, 32'h100);
        chk1("s1_stall_N1", stall, 1'b1);
        m_data_valid = 1'b1;
        m_data_read  = 32'h1234_5678;
        sb.push_back('{1'b0, 32'h1234_5678});
        nxt();
        m_data_valid = 1'b0;
        dm_load = 1'b0;
        #2;
        chk1("s1_dm_valid_N2", dm_valid, 1'b1);
        chk("s1_rdata_N2", dm_rdata, 32'h1234_5678);
        chk1("s1_stall_N2", stall, 1'b0);
        chk1("s1_ren_N2", m_read_enable, 1'b0);
        nxt(); #2;
        chk1("s1_pulse_once", dm_valid, 1'b0);
        chk("s1_rdata_hold", dm_rdata, 32'h1234_5678);

        // Store with the memory answering on the fourth strobe cycle.
        nxt();
        dm_store = 1'b1;
        dm_address = 32'h40;
        dm_wdata = 32'hCAFE_F00D;
        #2;
        for (int k = 0; k < 4; k++) begin
            nxt(); #2;
            chk1("s2_wen", m_write_enable, 1'b1);
            chk1("s2_ren", m_read_enable, 1'b0);
            chk("s2_addr", m_address, 32'h40);
            chk("s2_wdata", m_data_write, 32'hCAFE_F00D);
            chk1("s2_stall", stall, 1'b1);
            chk1("s2_no_early_valid", dm_valid, 1'b0);
        end
        m_data_valid = 1'b1;
        m_data_read  = 32'h0BAD_F00D;
        sb.push_back('{1'b0, 32'h0BAD_F00D});
        nxt();
        m_data_valid = 1'b0;
        dm_store = 1'b0;
        #2;
        chk1("s2_dm_valid", dm_valid, 1'b1);
        chk1("s2_stall_done", stall, 1'b0);
        chk1("s2_wen_done", m_write_enable, 1'b0);
        nxt(); #2;
        chk1("s2_pulse_once", dm_valid, 1'b0);

        // Stray completion while idle must be ignored.
        nxt();
        m_data_valid = 1'b1;
        m_data_read  = 32'hFFFF_0000;
        #2;
        chk1("s3_stall", stall, 1'b0);
        nxt();
        m_data_valid = 1'b0;
        #2;
        chk1("s3_dm_valid", dm_valid, 1'b0);
        chk1("s3_if_valid", if_valid, 1'b0);
        chk1("s3_ren", m_read_enable, 1'b0);
        chk1("s3_wen", m_write_enable, 1'b0);
        chk("s3_dm_rdata_hold", dm_rdata, 32'h0BAD_F00D);
        chk("s3_if_data_hold", if_data, 32'h0);

        // Continuous contention: data wins four times, then fetch once.
        nxt();
        if_req = 1'b1;
        if_address = 32'h2000;
        dm_load = 1'b1;
        dm_address = 32'h3000;
        #2;
        chk1("s4_stall_contend", stall, 1'b1);
        mcnt = 0;
        for (int g = 0; g < 10; g++) begin
            bit efetch;
            int w;
            efetch = (mcnt == 4);
            w = 0;
            do begin
                nxt(); #2;
                w++;
            end while (m_read_enable !== 1'b1 && w < 6);
            chk1("s4_grant_seen", m_read_enable, 1'b1);
            chk("s4_grant_addr", m_address, efetch ? 32'h2000 : 32'h3000);
            m_data_valid = 1'b1;
            m_data_read  = 32'hA000_0000 + 32'(g);
            sb.push_back('{efetch, 32'hA000_0000 + 32'(g)});
            nxt();
            m_data_valid = 1'b0;
            if (efetch) mcnt = 0;
            else if (mcnt < 4) mcnt++;
        end
        if_req = 1'b0;
        dm_load = 1'b0;
        nxt(); #2;
        chk("s4_sb_drained", 32'(sb.size()), 32'd0);
        chk1("s4_idle_ren", m_read_enable, 1'b0);
        chk1("s4_idle_stall", stall, 1'b0);

        // Reset in the middle of a data access.
        nxt();
        dm_load = 1'b1;
        dm_address = 32'h500;
        #2;
        nxt(); #2;
        chk1("s5_ren_busy", m_read_enable, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk1("s5_ren_async", m_read_enable, 1'b0);
        chk1("s5_wen_async", m_write_enable, 1'b0);
        chk1("s5_stall_async", stall, 1'b0);
        chk("s5_addr_async", m_address, 32'h0);
        nxt();
        nxt();
        dm_load = 1'b0;
        #1 reset = 1'b0;
        nxt(); #2;
        chk1("s5_ren_after", m_read_enable, 1'b0);
        chk1("s5_stall_after", stall, 1'b0);
        chk1("s5_no_dm_valid", dm_valid, 1'b0);
        chk("s5_rdata_cleared", dm_rdata, 32'h0);

        // Lone fetch after reset release: arbiter is back in IDLE.
        nxt();
        if_req = 1'b1;
        if_address = 32'h700;
        #2;
        nxt(); #2;
        chk1("s6_ren", m_read_enable, 1'b1);
        chk("s6_addr", m_address, 32'h700);
        m_data_valid = 1'b1;
        m_data_read  = 32'h7777_0000;
        sb.push_back('{1'b1, 32'h7777_0000});
        nxt();
        m_data_valid = 1'b0;
        if_req = 1'b0;
        #2;
        chk1("s6_if_valid", if_valid, 1'b1);
        chk("s6_if_data", if_data, 32'h7777_0000);
        chk1("s6_bus_error", bus_error, 1'b0);

`ifdef MEM_PORT_ARB_TIMEOUT_EN
        // Load that the memory never answers: watchdog completes it.
        nxt();
        dm_load = 1'b1;
        dm_address = 32'h600;
        #2;
        nxt(); #2;
        chk1("s7_ren_first", m_read_enable, 1'b1);
        sb.push_back('{1'b0, 32'hDEAD_BEEF});
        for (int w = 1; w < 16; w++) begin
            nxt(); #2;
            chk1("s7_waiting_ren", m_read_enable, 1'b1);
            chk1("s7_no_early_valid", dm_valid, 1'b0);
            chk1("s7_no_early_err", bus_error, 1'b0);
        end
        nxt();
        dm_load = 1'b0;
        #2;
        chk1("s7_bus_error", bus_error, 1'b1);
        chk1("s7_dm_valid", dm_valid, 1'b1);
        chk("s7_rdata", dm_rdata, 32'hDEAD_BEEF);
        nxt(); #2;
        chk1("s7_err_once", bus_error, 1'b0);
        chk1("s7_ren_idle", m_read_enable, 1'b0);
`endif

        nxt(); #2;
        chk("final_sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- STARVE_LIMIT, 4: consecutive lost arbitrations after which fetch wins.
- TIMEOUT_CYCLES, 16: watchdog limit in cycles.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1: single clock.
- reset, in, 1: asynchronous, active-high reset.
- if_req, in, 1: fetch read request.
- if_address, in, 32: fetch address.
- if_valid, out, 1: fetch data valid pulse.
- if_data, out, 32: fetch data.
- dm_load, in, 1: data load request.
- dm_store, in, 1: data store request.
- dm_address, in, 32: data address.
- dm_wdata, in, 32: store data.
- dm_valid, out, 1: data access complete pulse.
- dm_rdata, out, 32: load data.
- m_address, out, 32: shared memory port address.
- m_data_write, out, 32: shared port write data.
- m_write_enable, out, 1: write strobe.
- m_read_enable, out, 1: read strobe.
- m_data_valid, in, 1: memory completion.
- m_data_read, in, 32: memory read data.
- stall, out, 1: pipeline freeze.
- bus_error, out, 1: timeout pulse (macro only).

Function
REQ-003 SHALL implement states IDLE, DATA_BUSY, INST_BUSY.
REQ-004 In IDLE, a request (if_req, or dm_load|dm_store) SHALL be latched, including address, data and type, and the FSM SHALL move to the matching BUSY state on the next edge.
REQ-005 Data SHALL win simultaneous requests, unless starve_cnt==STARVE_LIMIT, in which case fetch SHALL win.
REQ-006 starve_cnt SHALL increment when fetch loses while if_req=1, SHALL clear on fetch grant, and SHALL saturate at STARVE_LIMIT.
REQ-007 Simultaneous dm_load and dm_store SHALL be treated as a store.
REQ-008 In BUSY, m_address, m_data_write, m_read_enable and m_write_enable SHALL be driven from the latched registers and held stable until m_data_valid.
- Store: m_write_enable=1, m_read_enable=0.
- Load or fetch: m_read_enable=1.
REQ-009 On m_data_valid in BUSY, the FSM SHALL return to IDLE on that edge.
REQ-010 On that same edge, the block SHALL register m_data_read into dm_rdata or if_data and SHALL pulse dm_valid or if_valid for exactly one cycle.
REQ-011 Minimum latency SHALL be: request at cycle N, strobe at N+1, m_data_valid at N+1, valid pulse at N+2, next grant possible at N+2.
REQ-012 stall SHALL be 1 whenever (state!=IDLE) or (a request is pending but not granted this cycle); it SHALL drop the cycle the completing valid pulse is asserted.
REQ-013 m_data_valid in IDLE SHALL be ignored.
REQ-014 Requests arriving while BUSY SHALL NOT be latched; requesters SHALL hold them until their valid pulse.
REQ-015 dm_rdata and if_data SHALL hold their last value between pulses.

Reset
REQ-016 When reset=1, state SHALL be IDLE, starve_cnt and watchdog SHALL be 0, and all outputs, registers and data SHALL be 0, immediately and without clk.
REQ-017 Reset mid-access SHALL abort the access with no valid pulse; the memory strobes SHALL drop asynchronously.

Configuration
REQ-018 With MEM_PORT_ARB_TIMEOUT_EN defined, a watchdog SHALL count cycles in BUSY.
- On reaching TIMEOUT_CYCLES without m_data_valid: return to IDLE, pulse bus_error and the requester's valid for one cycle, and set the returned data to 32'hDEAD_BEEF.
- The counter SHALL clear on every grant.
REQ-019 Without MEM_PORT_ARB_TIMEOUT_EN, the bus_error port SHALL exist, tied to 0, with no counter logic, and BUSY SHALL wait indefinitely.

Structure
REQ-020 Package mem_arb_pkg SHALL hold the state enum, the access-type enum (ACC_LOAD, ACC_STORE, ACC_FETCH), the default STARVE_LIMIT and TIMEOUT_CYCLES, and the 32'hDEAD_BEEF constant.
REQ-021 The watchdog SHALL be the sub-module mem_arb_watchdog: inputs clear and run; output expired.

Verification
REQ-022 The bench SHALL cover these directed scenarios, one per line: stimulus -> required response.
- dm_load, dm_address=0x100; m_data_valid one cycle later with 0x12345678 -> m_read_enable at N+1, dm_valid and dm_rdata=0x12345678 at N+2, stall low at N+2.
- dm_store, dm_wdata=0xCAFEF00D, address=0x40; m_data_valid delayed 3 cycles -> m_write_enable and signals stable for 4 cycles, stall high throughout, single dm_valid pulse.
- if_req and dm_load held continuously -> grants D,D,D,D,I repeating; starve_cnt resets after the I grant.
- Reset asserted while DATA_BUSY -> strobes drop without clk, no dm_valid, IDLE after release.
- With MEM_PORT_ARB_TIMEOUT_EN: load with no m_data_valid -> bus_error and dm_valid at cycle 16 after grant, dm_rdata=0xDEADBEEF.
- m_data_valid pulse in IDLE -> no valid pulses, no state change.
